ram_dp_clr: RTL and testbench

Simple dual-port synchronous RAM with independent write and read ports. It is the storage stage driven by the RAM write and read agents. After every reset, an internal sequencer clears every location to a known value before the block accepts traffic. Reads are registered, so data returns with one cycle of latency and a valid strobe. This block is the DUT of the RAM verification environment.

---
 rtl/ram_dp_clr_if.sv | 27 ++
 rtl/ram_dp_clr.sv | 67 ++++++
 tb/tb_ram_dp_clr.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_dp_clr_if.sv
// Request/response bundle between the RAM agents and ram_dp_clr.
// The master drives write/read requests; the slave returns read data and status.
interface ram_dp_clr_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              wr_enb;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_enb;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              init_busy;
    logic              wr_drop;
    logic              rd_drop;

    modport master (
        output wr_enb, wr_addr, wr_data, rd_enb, rd_addr,
        input  rd_data, rd_valid, init_busy, wr_drop, rd_drop
    );

    modport slave (
        input  wr_enb, wr_addr, wr_data, rd_enb, rd_addr,
        output rd_data, rd_valid, init_busy, wr_drop, rd_drop
    );
endinterface

// File: rtl/ram_dp_clr.sv
// Simple dual-port RAM with registered, write-first reads and a post-reset
// clear sequence that fills every location with INIT_VAL before accepting traffic.
module ram_dp_clr #(
    parameter int                ADDR_W   = 4,
    parameter int                DATA_W   = 8,
    parameter int                DEPTH    = 16,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input logic         clk,
    input logic         rst,
    ram_dp_clr_if.slave bus
);
    typedef enum logic {INIT, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on the array. While rst is held, state/clr_ptr sit at INIT/0,
    // so the extra writes of INIT_VAL to location 0 are harmless.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[clr_ptr] <= INIT_VAL;
        end else if (bus.wr_enb) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= INIT;
            clr_ptr       <= '0;
            bus.init_busy <= 1'b1;
            bus.wr_drop   <= 1'b0;
            bus.rd_drop   <= 1'b0;
            bus.rd_valid  <= 1'b0;
            bus.rd_data   <= '0;
        end else begin
            case (state)
                INIT: begin
                    clr_ptr      <= clr_ptr + ADDR_W'(1);
                    bus.wr_drop  <= bus.wr_enb;
                    bus.rd_drop  <= bus.rd_enb;
                    bus.rd_valid <= 1'b0;
                    if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
                        state         <= RUN;
                        bus.init_busy <= 1'b0;
                    end
                end
                RUN: begin
                    bus.wr_drop  <= 1'b0;
                    bus.rd_drop  <= 1'b0;
                    bus.rd_valid <= bus.rd_enb;
                    // Write-first: a same-address write bypasses the array.
                    if (bus.rd_enb) begin
                        if (bus.wr_enb && (bus.wr_addr == bus.rd_addr)) begin
                            bus.rd_data <= bus.wr_data;
                        end else begin
                            bus.rd_data <= mem[bus.rd_addr];
                        end
                    end
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_dp_clr.sv
// Self-checking bench for ram_dp_clr: reference memory model plus a queue of
// expected read words popped whenever rd_valid is seen.
module tb_ram_dp_clr;
    logic clk = 1'b0;
    logic rst = 1'b1;

    ram_dp_clr_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    ram_dp_clr #(
        .ADDR_W(4), .DATA_W(8), .DEPTH(16), .INIT_VAL(8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int unsigned passed = 0;
    int unsigned total  = 0;
    logic [7:0]  model [16];
    logic [7:0]  exp_q [$];
    logic [7:0]  exp_d;

    // Advance one posedge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_enb  = 1'b0;
        bus.rd_enb  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_addr = '0;
    endtask

    task automatic clear_model();
        for (int unsigned i = 0; i < 16; i++) model[i] = 8'h00;
    endtask

    task automatic test_reset();
        idle();
        clear_model();
        rst = 1'b1;
        #20;
        rst = 1'b0;
        total++;
        if ({bus.rd_data, bus.rd_valid, bus.wr_drop, bus.rd_drop, bus.init_busy} !== {8'h00, 4'b0001})
            $display("FAIL reset_values: got data=%h v=%b wd=%b rd=%b busy=%b required 00 0 0 0 1",
                     bus.rd_data, bus.rd_valid, bus.wr_drop, bus.rd_drop, bus.init_busy);
        else passed++;
        for (int unsigned e = 1; e <= 16; e++) begin
            step();
            total++;
            if (bus.init_busy !== (e < 16))
                $display("FAIL init_busy_edge%0d: got %b required %b", e, bus.init_busy, e < 16);
            else passed++;
        end
        for (int unsigned i = 0; i < 16; i++) begin
            bus.rd_enb  = 1'b1;
            bus.rd_addr = 4'(i);
            exp_q.push_back(model[i]);
            step();
            total++;
            if (bus.rd_valid !== 1'b1 || exp_q.size() == 0) begin
                $display("FAIL init_read_valid%0d: got %b required 1", i, bus.rd_valid);
            end else begin
                exp_d = exp_q.pop_front();
                if (bus.rd_data !== exp_d)
                    $display("FAIL init_read%0d: got %h required %h", i, bus.rd_data, exp_d);
                else passed++;
            end
        end
        idle();
        step();
    endtask

    task automatic test_write_read();
        bus.wr_enb = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 8'hA5;
        model[3] = 8'hA5;
        step();
        idle();
        bus.rd_enb = 1'b1; bus.rd_addr = 4'd3;
        exp_q.push_back(model[3]);
        step();
        idle();
        total++;
        if (bus.rd_valid !== 1'b1 || exp_q.size() == 0) begin
            $display("FAIL wr_rd_valid: got %b required 1", bus.rd_valid);
        end else begin
            exp_d = exp_q.pop_front();
            if (bus.rd_data !== exp_d) $display("FAIL wr_rd_data: got %h required %h", bus.rd_data, exp_d);
            else passed++;
        end
        step();
        total++;
        if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'hA5)
            $display("FAIL wr_rd_idle: got v=%b data=%h required v=0 data=a5", bus.rd_valid, bus.rd_data);
        else passed++;
    endtask

    task automatic test_write_first();
        bus.wr_enb = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 8'h3C;
        bus.rd_enb = 1'b1; bus.rd_addr = 4'd7;
        exp_q.push_back(8'h3C);
        model[7] = 8'h3C;
        for (int unsigned k = 0; k < 2; k++) begin
            step();
            bus.wr_enb = 1'b0;
            if (k == 0) exp_q.push_back(model[7]);
            else        bus.rd_enb = 1'b0;
            total++;
            if (bus.rd_valid !== 1'b1 || exp_q.size() == 0) begin
                $display("FAIL wfirst_valid%0d: got %b required 1", k, bus.rd_valid);
            end else begin
                exp_d = exp_q.pop_front();
                if (bus.rd_data !== exp_d)
                    $display("FAIL wfirst_data%0d: got %h required %h", k, bus.rd_data, exp_d);
                else passed++;
            end
        end
        idle();
        step();
    endtask

    task automatic test_init_drop();
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_model();
        for (int unsigned e = 1; e <= 4; e++) step();
        bus.wr_enb = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 8'hFF;
        bus.rd_enb = 1'b1; bus.rd_addr = 4'd2;
        step();
        idle();
        total++;
        if ({bus.wr_drop, bus.rd_drop, bus.rd_valid, bus.init_busy} !== 4'b1101)
            $display("FAIL init_drop_pulse: got wd=%b rd=%b v=%b busy=%b required 1 1 0 1",
                     bus.wr_drop, bus.rd_drop, bus.rd_valid, bus.init_busy);
        else passed++;
        step();
        total++;
        if ({bus.wr_drop, bus.rd_drop} !== 2'b00)
            $display("FAIL init_drop_one_cycle: got wd=%b rd=%b required 0 0", bus.wr_drop, bus.rd_drop);
        else passed++;
        for (int unsigned e = 7; e <= 15; e++) step();
        // Request on the final clear edge must still be dropped.
        bus.wr_enb = 1'b1; bus.wr_addr = 4'd4; bus.wr_data = 8'h77;
        bus.rd_enb = 1'b1; bus.rd_addr = 4'd4;
        step();
        idle();
        total++;
        if ({bus.wr_drop, bus.rd_drop, bus.rd_valid, bus.init_busy} !== 4'b1100)
            $display("FAIL last_edge_drop: got wd=%b rd=%b v=%b busy=%b required 1 1 0 0",
                     bus.wr_drop, bus.rd_drop, bus.rd_valid, bus.init_busy);
        else passed++;
        for (int unsigned k = 0; k < 2; k++) begin
            bus.rd_enb  = 1'b1;
            bus.rd_addr = (k == 0) ? 4'd2 : 4'd4;
            exp_q.push_back(model[bus.rd_addr]);
            step();
            total++;
            if (bus.rd_valid !== 1'b1 || exp_q.size() == 0) begin
                $display("FAIL drop_read_valid%0d: got %b required 1", k, bus.rd_valid);
            end else begin
                exp_d = exp_q.pop_front();
                if (bus.rd_data !== exp_d)
                    $display("FAIL drop_read%0d: got %h required %h", k, bus.rd_data, exp_d);
                else passed++;
            end
        end
        idle();
        step();
    endtask

    task automatic test_back_to_back();
        for (int unsigned i = 0; i < 16; i++) begin
            bus.wr_enb  = 1'b1;
            bus.wr_addr = 4'(i);
            bus.wr_data = 8'(i * 8'h11);
            model[i]    = 8'(i * 8'h11);
            step();
        end
        idle();
        for (int unsigned i = 0; i < 16; i++) begin
            bus.rd_enb  = 1'b1;
            bus.rd_addr = 4'(i);
            exp_q.push_back(model[i]);
            step();
            total++;
            if (bus.rd_valid !== 1'b1 || exp_q.size() == 0) begin
                $display("FAIL b2b_valid%0d: got %b required 1", i, bus.rd_valid);
            end else begin
                exp_d = exp_q.pop_front();
                if (bus.rd_data !== exp_d)
                    $display("FAIL b2b_data%0d: got %h required %h", i, bus.rd_data, exp_d);
                else passed++;
            end
        end
        idle();
        step();
    endtask

    task automatic test_reset_mid();
        bus.wr_enb = 1'b1; bus.wr_addr = 4'd9; bus.wr_data = 8'h5A;
        step();
        idle();
        bus.rd_enb = 1'b1; bus.rd_addr = 4'd9;
        step();
        idle();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({bus.rd_data, bus.rd_valid, bus.init_busy} !== {8'h00, 2'b01})
            $display("FAIL mid_reset: got data=%h v=%b busy=%b required 00 0 1",
                     bus.rd_data, bus.rd_valid, bus.init_busy);
        else passed++;
        step();
        rst = 1'b0;
        clear_model();
        for (int unsigned e = 1; e <= 16; e++) step();
        total++;
        if (bus.init_busy !== 1'b0) $display("FAIL reinit_busy: got %b required 0", bus.init_busy);
        else passed++;
        bus.rd_enb = 1'b1; bus.rd_addr = 4'd9;
        exp_q.push_back(model[9]);
        step();
        idle();
        total++;
        if (bus.rd_valid !== 1'b1 || exp_q.size() == 0) begin
            $display("FAIL reinit_read_valid: got %b required 1", bus.rd_valid);
        end else begin
            exp_d = exp_q.pop_front();
            if (bus.rd_data !== exp_d) $display("FAIL reinit_read: got %h required %h", bus.rd_data, exp_d);
            else passed++;
        end
        step();
        total++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_write_first();
        test_init_drop();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
